// File: rtl/uart_bench_agent.sv
// Bench-side UART agent: sequenced core reset, queued serial stimulus on the core rx line,
// monitor of the core tx line with framing-error detection, and a cycle counter with timeout.
`timescale 1ns/1ps
module uart_bench_agent #(
   parameter int CLKS_PER_BIT   = 16,
   parameter int DATA_BITS      = 8,
   parameter int FIFO_DEPTH     = 8,
   parameter int RST_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int CNT_W          = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic                 core_rst_n,
   output logic                 uart_rx_out,
   input  logic                 uart_tx_in,
   input  logic [DATA_BITS-1:0] stim_data,
   input  logic                 stim_valid,
   output logic                 stim_ready,
   output logic                 tx_busy,
   output logic [DATA_BITS-1:0] mon_data,
   output logic                 mon_valid,
   output logic                 mon_frame_err,
   output logic [CNT_W-1:0]     cycle_count,
   output logic                 timeout
);
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int RW = $clog2(RST_CYCLES + 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] BIT_END   = BW'(DATA_BITS - 1);

   localparam logic [1:0] TX_IDLE = 2'd0, TX_START = 2'd1, TX_DATA = 2'd2, TX_STOP = 2'd3;
   localparam logic [2:0] RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2, RX_STOP = 3'd3,
                          RX_WAIT_HIGH = 3'd4;

   logic [RW-1:0] rst_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_cnt    <= '0;
         core_rst_n <= 1'b0;
      end else if (!core_rst_n) begin
         if (rst_cnt == RW'(RST_CYCLES - 1)) core_rst_n <= 1'b1;
         else rst_cnt <= rst_cnt + 1'b1;
      end
   end

   // stimulus queue: extra pointer bit distinguishes full from empty
   logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
   logic [AW:0]          wr_ptr, rd_ptr;
   logic                 fifo_empty, fifo_full, push, pop;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign stim_ready = !fifo_full;
   assign push       = stim_valid && !fifo_full;

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr[AW-1:0]] <= stim_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   logic [1:0]           tx_state;
   logic [CW-1:0]        tx_cnt;
   logic [BW-1:0]        tx_bit;
   logic [DATA_BITS-1:0] tx_shift, tx_next;
   logic                 tx_bit_done;

   assign tx_bit_done = (tx_cnt == BIT_LAST);
   assign tx_next     = tx_shift >> 1;
   assign pop         = !fifo_empty && ((tx_state == TX_IDLE && core_rst_n) ||
                                        (tx_state == TX_STOP && tx_bit_done));
   assign tx_busy     = (tx_state != TX_IDLE) || !fifo_empty;

   always_ff @(posedge clk) begin
      if (pop) tx_shift <= fifo_mem[rd_ptr[AW-1:0]];
      else if (tx_state == TX_DATA && tx_bit_done) tx_shift <= tx_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state    <= TX_IDLE;
         tx_cnt      <= '0;
         tx_bit      <= '0;
         uart_rx_out <= 1'b1;
      end else begin
         case (tx_state)
            TX_IDLE: if (pop) begin
               tx_state    <= TX_START;
               tx_cnt      <= '0;
               uart_rx_out <= 1'b0;
            end
            TX_START: if (tx_bit_done) begin
               tx_state    <= TX_DATA;
               tx_cnt      <= '0;
               tx_bit      <= '0;
               uart_rx_out <= tx_shift[0];
            end else tx_cnt <= tx_cnt + 1'b1;
            TX_DATA: if (tx_bit_done) begin
               tx_cnt <= '0;
               if (tx_bit == BIT_END) begin
                  tx_state    <= TX_STOP;
                  uart_rx_out <= 1'b1;
               end else begin
                  tx_bit      <= tx_bit + 1'b1;
                  uart_rx_out <= tx_next[0];
               end
            end else tx_cnt <= tx_cnt + 1'b1;
            TX_STOP: if (tx_bit_done) begin
               tx_cnt <= '0;
               // back-to-back frames skip IDLE so there is no gap on the line
               if (pop) begin
                  tx_state    <= TX_START;
                  uart_rx_out <= 1'b0;
               end else tx_state <= TX_IDLE;
            end else tx_cnt <= tx_cnt + 1'b1;
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   logic                 rx_s1, rx_s2, rx_prev;
   logic [2:0]           rx_state;
   logic [CW-1:0]        rx_cnt;
   logic [BW-1:0]        rx_bit;
   logic [DATA_BITS-1:0] rx_shift;
   logic [DATA_BITS:0]   rx_cat;

   assign rx_cat = {rx_s2, rx_shift};

   always_ff @(posedge clk) begin
      if (rx_state == RX_DATA && rx_cnt == BIT_LAST) rx_shift <= rx_cat[DATA_BITS:1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1         <= 1'b1;
         rx_s2         <= 1'b1;
         rx_prev       <= 1'b1;
         rx_state      <= RX_IDLE;
         rx_cnt        <= '0;
         rx_bit        <= '0;
         mon_data      <= '0;
         mon_valid     <= 1'b0;
         mon_frame_err <= 1'b0;
      end else begin
         rx_s1         <= uart_tx_in;
         rx_s2         <= rx_s1;
         rx_prev       <= rx_s2;
         mon_valid     <= 1'b0;
         mon_frame_err <= 1'b0;
         case (rx_state)
            RX_IDLE: if (rx_prev && !rx_s2) begin
               rx_state <= RX_START;
               rx_cnt   <= '0;
            end
            RX_START: if (rx_cnt == HALF_LAST) begin
               rx_cnt <= '0;
               rx_bit <= '0;
               // a line already back high at mid-start was a glitch
               rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
            end else rx_cnt <= rx_cnt + 1'b1;
            RX_DATA: if (rx_cnt == BIT_LAST) begin
               rx_cnt <= '0;
               if (rx_bit == BIT_END) rx_state <= RX_STOP;
               else rx_bit <= rx_bit + 1'b1;
            end else rx_cnt <= rx_cnt + 1'b1;
            RX_STOP: if (rx_cnt == BIT_LAST) begin
               rx_cnt   <= '0;
               mon_data <= rx_shift;
               if (rx_s2) begin
                  mon_valid <= 1'b1;
                  rx_state  <= RX_IDLE;
               end else begin
                  mon_frame_err <= 1'b1;
                  rx_state      <= RX_WAIT_HIGH;
               end
            end else rx_cnt <= rx_cnt + 1'b1;
            RX_WAIT_HIGH: if (rx_s2) rx_state <= RX_IDLE;
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_count <= '0;
         timeout     <= 1'b0;
      end else if (core_rst_n && cycle_count != '1) begin
         cycle_count <= cycle_count + 1'b1;
         if (TIMEOUT_CYCLES != 0 && (cycle_count + 1'b1) == CNT_W'(TIMEOUT_CYCLES))
            timeout <= 1'b1;
      end
   end
endmodule
